// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART write-stream arbiter.
//  state_t          arbiter FSM encoding (IDLE / TAG / DATA)
//  TAG_BASE_DEFAULT default tag byte base; the requester index is ORed into the low bits
//  idx_w()          width of a requester index for a given requester count
package uart_pkg;
   typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;
   localparam logic [7:0] TAG_BASE_DEFAULT = 8'hF0;
   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin search over a valid vector.
//  valid  in   NUM_REQ  requesters currently asking
//  ptr    in   IW       last served index; the search starts at ptr+1 and wraps
//  found  out  1        any requester valid
//  idx    out  IW       first valid index in round-robin order
module uart_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IW = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IW-1:0]      ptr,
   output logic               found,
   output logic [IW-1:0]      idx
);
   logic [IW-1:0] c;
   // Scan from the farthest offset down so the nearest valid index wins.
   always_comb begin
      found = |valid;
      idx = '0;
      c = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         c = IW'((int'(ptr) + k) % NUM_REQ);
         if (valid[c]) idx = c;
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UartCtrl write stream between NUM_REQ packet requesters.
//  io_mainClk / resetCtrl_systemReset   clock, asynchronous active-high reset
//  io_req_valid/ready/payload/last      per-requester byte streams, byte i at [8*i+7:8*i]
//  io_uart_write_valid/ready/payload    UartCtrl write stream
//  io_grant                             one-hot packet owner, 0 when idle
//  io_busy                              high while a packet (tag or data) is open
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int         NUM_REQ  = 4,
   parameter bit         TAG_EN   = 1'b1,
   parameter logic [7:0] TAG_BASE = TAG_BASE_DEFAULT
) (
   input  logic                   io_mainClk,
   input  logic                   resetCtrl_systemReset,
   input  logic [NUM_REQ-1:0]     io_req_valid,
   output logic [NUM_REQ-1:0]     io_req_ready,
   input  logic [8*NUM_REQ-1:0]   io_req_payload,
   input  logic [NUM_REQ-1:0]     io_req_last,
   output logic                   io_uart_write_valid,
   input  logic                   io_uart_write_ready,
   output logic [7:0]             io_uart_write_payload,
   output logic [NUM_REQ-1:0]     io_grant,
   output logic                   io_busy
);
   localparam int IW = idx_w(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
   end

   state_t        state, state_nxt;
   logic [IW-1:0] owner, owner_nxt, ptr, ptr_nxt, pick;
   logic          found;
   logic [7:0]    pay [NUM_REQ];

   uart_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
      .valid (io_req_valid),
      .ptr   (ptr),
      .found (found),
      .idx   (pick)
   );

   always_comb
      for (int i = 0; i < NUM_REQ; i++) pay[i] = io_req_payload[8*i +: 8];

   always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset)
      if (resetCtrl_systemReset) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= IW'(NUM_REQ - 1);
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         ptr   <= ptr_nxt;
      end

   // The round-robin pointer only moves when a packet completes.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      case (state)
         IDLE: if (found) begin
            owner_nxt = pick;
            state_nxt = TAG_EN ? TAG : DATA;
         end
         TAG:  if (io_uart_write_ready) state_nxt = DATA;
         DATA: if (io_req_valid[owner] && io_uart_write_ready && io_req_last[owner]) begin
            state_nxt = IDLE;
            ptr_nxt   = owner;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Data beats pass straight through from the owner with no added latency.
   always_comb begin
      io_busy               = state != IDLE;
      io_grant              = io_busy ? NUM_REQ'(1) << owner : '0;
      io_uart_write_valid   = state == TAG || (state == DATA && io_req_valid[owner]);
      io_uart_write_payload = state == TAG ? (TAG_BASE | 8'(owner)) : state == DATA ? pay[owner] : 8'h00;
      io_req_ready          = (state == DATA && io_uart_write_ready) ? io_grant : '0;
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (tagged and untagged instances).
module tb_uart_tx_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  v0 = '0, r0, l0 = '0, g0;
   logic [31:0] p0 = '0;
   logic        uv0, ur0 = 1'b1, b0;
   logic [7:0]  up0;
   logic [3:0]  v1 = '0, r1, l1 = '0, g1;
   logic [31:0] p1 = '0;
   logic        uv1, ur1 = 1'b1, b1;
   logic [7:0]  up1;

   int          total = 0, bad = 0, cyc = 0;
   logic [8:0]  rq [4][$];
   logic [8:0]  rq3 [$];
   logic [11:0] eq0 [$], eq1 [$];
   logic [11:0] e0, e1;
   int          hs1_t [$];
   logic [3:0]  hs_d;
   logic        hs1_d;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_arbiter #(.NUM_REQ(4), .TAG_EN(1'b1), .TAG_BASE(8'hF0)) u_dut0 (
      .io_mainClk(clk), .resetCtrl_systemReset(rst),
      .io_req_valid(v0), .io_req_ready(r0), .io_req_payload(p0), .io_req_last(l0),
      .io_uart_write_valid(uv0), .io_uart_write_ready(ur0), .io_uart_write_payload(up0),
      .io_grant(g0), .io_busy(b0));

   uart_tx_arbiter #(.NUM_REQ(4), .TAG_EN(1'b0), .TAG_BASE(8'hF0)) u_dut1 (
      .io_mainClk(clk), .resetCtrl_systemReset(rst),
      .io_req_valid(v1), .io_req_ready(r1), .io_req_payload(p1), .io_req_last(l1),
      .io_uart_write_valid(uv1), .io_uart_write_ready(ur1), .io_uart_write_payload(up1),
      .io_grant(g1), .io_busy(b1));

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s: got %h expected %h", n, a, x);
      end
   endtask

   // Monitor: every accepted uart beat is checked against the scoreboard.
   always @(negedge clk) begin
      if (uv0 && ur0) begin
         if (eq0.size() == 0) begin
            total++; bad++;
            $display("FAIL dut0 unexpected beat: got %h expected none", up0);
         end else begin
            e0 = eq0.pop_front();
            chk("dut0 byte", 32'(up0), 32'(e0[7:0]));
            chk("dut0 grant", 32'(g0), 32'(e0[11:8]));
         end
      end
      if (uv1 && ur1) begin
         hs1_t.push_back(cyc);
         if (eq1.size() == 0) begin
            total++; bad++;
            $display("FAIL dut1 unexpected beat: got %h expected none", up1);
         end else begin
            e1 = eq1.pop_front();
            chk("dut1 byte", 32'(up1), 32'(e1[7:0]));
            chk("dut1 grant", 32'(g1), 32'(e1[11:8]));
         end
      end
   end

   // Requester drivers: present queue fronts, pop on handshake.
   initial forever begin
      @(negedge clk);
      hs_d  = v0 & r0;
      hs1_d = v1[3] & r1[3];
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (hs_d[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         v0[i]         = rq[i].size() > 0;
         p0[8*i +: 8]  = v0[i] ? rq[i][0][7:0] : 8'h00;
         l0[i]         = v0[i] && rq[i][0][8];
      end
      if (hs1_d && rq3.size() > 0) void'(rq3.pop_front());
      v1[3]     = rq3.size() > 0;
      p1[31:24] = v1[3] ? rq3[0][7:0] : 8'h00;
      l1[3]     = v1[3] && rq3[0][8];
   end

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < 4; i++) rq[i].delete();
      rq3.delete();
      eq0.delete();
      eq1.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic drain(input string n);
      for (int k = 0; k < 300 && (eq0.size() != 0 || eq1.size() != 0); k++) @(posedge clk);
      @(posedge clk);
      chk({n, " drain"}, 32'(eq0.size() + eq1.size()), 32'd0);
   endtask

   task automatic wait_byte(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
         @(negedge clk);
         hit = uv0 && up0 == b;
      end
      chk("wait byte seen", 32'(hit), 32'd1);
   endtask

   initial begin
      // 1: reset values, then single-byte packet from req0
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst valid", 32'(uv0), 32'd0);
      chk("rst ready", 32'(r0), 32'd0);
      chk("rst grant", 32'(g0), 32'd0);
      chk("rst busy", 32'(b0), 32'd0);
      chk("rst payload", 32'(up0), 32'd0);
      chk("rst dut1", 32'({uv1, r1, g1, b1, up1}), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      rq[0].push_back(9'h111);
      eq0.push_back(12'h1F0); eq0.push_back(12'h111);
      drain("t1");
      // 2: req1 and req2 contend; packets must not interleave
      rq[1].push_back(9'h0A1); rq[1].push_back(9'h0B1); rq[1].push_back(9'h1C1);
      rq[2].push_back(9'h0D2); rq[2].push_back(9'h0E2); rq[2].push_back(9'h1F2);
      eq0.push_back(12'h2F1); eq0.push_back(12'h2A1); eq0.push_back(12'h2B1); eq0.push_back(12'h2C1);
      eq0.push_back(12'h4F2); eq0.push_back(12'h4D2); eq0.push_back(12'h4E2); eq0.push_back(12'h4F2);
      drain("t2");
      // 3: all four requesting, round-robin from a fresh reset
      do_reset();
      rq[0].push_back(9'h130); rq[0].push_back(9'h140);
      rq[1].push_back(9'h131); rq[2].push_back(9'h132); rq[3].push_back(9'h133);
      eq0.push_back(12'h1F0); eq0.push_back(12'h130); eq0.push_back(12'h2F1); eq0.push_back(12'h231);
      eq0.push_back(12'h4F2); eq0.push_back(12'h432); eq0.push_back(12'h8F3); eq0.push_back(12'h833);
      eq0.push_back(12'h1F0); eq0.push_back(12'h140);
      drain("t3");
      // 4: uart back-pressure mid-packet
      do_reset();
      rq[1].push_back(9'h05A); rq[1].push_back(9'h06B); rq[1].push_back(9'h17C);
      eq0.push_back(12'h2F1); eq0.push_back(12'h25A); eq0.push_back(12'h26B); eq0.push_back(12'h27C);
      wait_byte(8'h5A);
      @(posedge clk);
      #2 ur0 = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("stall valid", 32'(uv0), 32'd1);
         chk("stall payload", 32'(up0), 32'h6B);
         chk("stall req ready", 32'(r0), 32'd0);
         chk("stall grant", 32'(g0), 32'h2);
      end
      @(posedge clk);
      #2 ur0 = 1'b1;
      drain("t4");
      // 5: untagged instance, two back-to-back bytes from req3
      hs1_t.delete();
      rq3.push_back(9'h0AA); rq3.push_back(9'h155);
      eq1.push_back(12'h8AA); eq1.push_back(12'h855);
      drain("t5");
      chk("t5 beats", 32'(hs1_t.size()), 32'd2);
      if (hs1_t.size() == 2) chk("t5 gap", 32'(hs1_t[1] - hs1_t[0]), 32'd1);
      // 6: reset in the middle of a req2 packet, then req0 wins over req2
      do_reset();
      rq[2].push_back(9'h021); rq[2].push_back(9'h022); rq[2].push_back(9'h123);
      eq0.push_back(12'h4F2); eq0.push_back(12'h421); eq0.push_back(12'h422); eq0.push_back(12'h423);
      wait_byte(8'h21);
      @(posedge clk);
      #2 rst = 1'b1;
      rq[2].delete();
      eq0.delete();
      @(negedge clk);
      chk("t6 grant", 32'(g0), 32'd0);
      chk("t6 busy", 32'(b0), 32'd0);
      chk("t6 valid", 32'(uv0), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      rq[0].push_back(9'h101); rq[2].push_back(9'h102);
      eq0.push_back(12'h1F0); eq0.push_back(12'h101); eq0.push_back(12'h4F2); eq0.push_back(12'h402);
      drain("t6");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
